// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator: Wishbone classic single-transfer bus master.
// Takes one command over a valid/ready port, runs exactly one Wishbone classic
// cycle, and returns read data plus status over a valid/ready response port.
// Optional feature macro: WBM_TIMEOUT_EN. When it is defined, a bus cycle
// without ack is aborted after TIMEOUT cycles and rsp_err_o is set. When it is
// undefined, BUS waits for ack indefinitely and rsp_err_o is tied to 0.
module wb_cmd_initiator #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TCNT_W  = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [3:0]  cmd_sel_i,
   input  logic [31:0] cmd_adr_i,
   input  logic [31:0] cmd_dat_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_dat_o,
   output logic        rsp_err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy_o
);

   // Reject parameter sets the timeout counter cannot represent.
   if (TIMEOUT < 1 || (TIMEOUT >> TCNT_W) != 0) begin : g_bad_cfg
      $error("wb_cmd_initiator: need TIMEOUT >= 1 and 2**TCNT_W > TIMEOUT");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic accept;
   logic bus_done;
   logic timeout_hit;

   assign accept   = (state == IDLE) && cmd_valid_i;
   assign bus_done = (state == BUS) && wbm_ack_i;

`ifdef WBM_TIMEOUT_EN
   logic [TCNT_W-1:0] tcnt;
   logic              rsp_err;

   // Timeout counter: counts BUS cycles that ended without ack.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         tcnt <= '0;
      end else if (accept) begin
         tcnt <= '0;
      end else if (state == BUS && !wbm_ack_i) begin
         tcnt <= tcnt + 1'b1;
      end
   end

   // An ack on the same edge as the timeout wins, so abort only without ack.
   assign timeout_hit = (state == BUS) && !wbm_ack_i && (tcnt == TCNT_W'(TIMEOUT - 1));

   // Error status: set on abort, cleared on a normal ack.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         rsp_err <= 1'b0;
      end else if (bus_done) begin
         rsp_err <= 1'b0;
      end else if (timeout_hit) begin
         rsp_err <= 1'b1;
      end
   end

   assign rsp_err_o = rsp_err;
`else
   assign timeout_hit = 1'b0;
   assign rsp_err_o   = 1'b0;
`endif

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; the reset branch is asynchronous.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode.
   // NOTE: the default assignment first keeps this combinational block free of
   // inferred latches on paths that do not change state.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid_i) state_nxt = BUS;
         BUS:     if (wbm_ack_i || timeout_hit) state_nxt = RESP;
         RESP:    if (rsp_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and bus-strobe outputs decoded from the state register.
   // cmd_ready_o is also gated by reset so every output reads 0 while it is held.
   always_comb begin
      cmd_ready_o = (state == IDLE) && !wb_rst_i;
      wbm_cyc_o   = (state == BUS);
      wbm_stb_o   = (state == BUS);
      rsp_valid_o = (state == RESP);
      busy_o      = (state != IDLE);
   end

   // Bus request registers: loaded on acceptance and held after the cycle ends.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= '0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
      end else if (accept) begin
         wbm_we_o  <= cmd_we_i;
         wbm_sel_o <= cmd_sel_i;
         wbm_adr_o <= cmd_adr_i;
         wbm_dat_o <= cmd_dat_i;
      end
   end

   // Response data: captured on ack (zero for writes) or zeroed on abort.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         rsp_dat_o <= '0;
      end else if (bus_done) begin
         rsp_dat_o <= wbm_we_o ? 32'h0 : wbm_dat_i;
      end else if (timeout_hit) begin
         rsp_dat_o <= 32'h0;
      end
   end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Testbench for wb_cmd_initiator. Acts as command source, Wishbone slave and
// response sink. Expected results come from the transfer rules: a slave with k
// wait states keeps cyc/stb up for k+1 cycles, reads return the slave data,
// writes return 0, and with WBM_TIMEOUT_EN a slave slower than TIMEOUT cycles
// produces an error response after exactly TIMEOUT cycles.
module tb_wb_cmd_initiator;

`ifdef WBM_TIMEOUT_EN
   localparam int TMO = 4;
`else
   localparam int TMO = 255;
`endif
   localparam int NEVER = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [3:0]  cmd_sel = '0;
   logic [31:0] cmd_adr = '0;
   logic [31:0] cmd_dat = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        wbm_cyc;
   logic        wbm_stb;
   logic        wbm_we;
   logic [3:0]  wbm_sel;
   logic [31:0] wbm_adr;
   logic [31:0] wbm_dat;
   logic [31:0] slv_dat = '0;
   logic        slv_ack = 1'b0;
   logic        busy;

   int errors = 0;
   int checks = 0;

   wb_cmd_initiator #(.TIMEOUT(TMO), .TCNT_W(8)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_we_i    (cmd_we),
      .cmd_sel_i   (cmd_sel),
      .cmd_adr_i   (cmd_adr),
      .cmd_dat_i   (cmd_dat),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_dat_o   (rsp_dat),
      .rsp_err_o   (rsp_err),
      .wbm_cyc_o   (wbm_cyc),
      .wbm_stb_o   (wbm_stb),
      .wbm_we_o    (wbm_we),
      .wbm_sel_o   (wbm_sel),
      .wbm_adr_o   (wbm_adr),
      .wbm_dat_o   (wbm_dat),
      .wbm_dat_i   (slv_dat),
      .wbm_ack_i   (slv_ack),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one complete transfer with a slave that acks after 'waits' wait states
   // and a sink that holds off the response for 'hold' cycles.
   task automatic do_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [31:0] rdata,
                          input int waits, input int hold);
      int          exp_cyc;
      logic        exp_err;
      logic [31:0] exp_dat;
      int          c;
`ifdef WBM_TIMEOUT_EN
      exp_err = (waits >= TMO);
      exp_cyc = exp_err ? TMO : waits + 1;
`else
      exp_err = 1'b0;
      exp_cyc = waits + 1;
`endif
      exp_dat = (we || exp_err) ? 32'h0 : rdata;

      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL xfer_ready: cmd_ready=%b want 1", cmd_ready);
      end
      cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
      tick();
      cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = ~sel;

      checks++;
      if ({wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat} !== {1'b1, 1'b1, we, sel, adr, dat}) begin
         errors++;
         $display("FAIL xfer_bus: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want 1 1 %b %h %h %h",
                  wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat, we, sel, adr, dat);
      end

      c = 0;
      while (wbm_cyc === 1'b1 && c < 100) begin
         slv_ack = (c == waits);
         slv_dat = (c == waits) ? rdata : $urandom;
         tick();
         c++;
      end
      slv_ack = 1'b0;

      checks++;
      if (c != exp_cyc) begin
         errors++;
         $display("FAIL xfer_cyc_len: cyc high %0d cycles want %0d", c, exp_cyc);
      end
      checks++;
      if ({rsp_valid, rsp_dat, rsp_err, cmd_ready, busy} !== {1'b1, exp_dat, exp_err, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL xfer_rsp: valid=%b dat=%h err=%b ready=%b busy=%b want 1 %h %b 0 1",
                  rsp_valid, rsp_dat, rsp_err, cmd_ready, busy, exp_dat, exp_err);
      end

      // Hold the response; spurious acks and stray commands must be ignored.
      for (int i = 0; i < hold; i++) begin
         slv_ack   = 1'($urandom_range(0, 1));
         slv_dat   = $urandom;
         cmd_valid = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if ({rsp_valid, rsp_dat, rsp_err, cmd_ready, wbm_cyc, wbm_adr} !==
             {1'b1, exp_dat, exp_err, 1'b0, 1'b0, adr}) begin
            errors++;
            $display("FAIL xfer_hold: valid=%b dat=%h err=%b ready=%b cyc=%b adr=%h want 1 %h %b 0 0 %h",
                     rsp_valid, rsp_dat, rsp_err, cmd_ready, wbm_cyc, wbm_adr, exp_dat, exp_err, adr);
         end
      end
      slv_ack = 1'b0; cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, cmd_ready, wbm_cyc, busy, wbm_we, wbm_adr} !== {1'b0, 1'b1, 1'b0, 1'b0, we, adr}) begin
         errors++;
         $display("FAIL xfer_done: valid=%b ready=%b cyc=%b busy=%b we=%b adr=%h want 0 1 0 0 %b %h",
                  rsp_valid, cmd_ready, wbm_cyc, busy, wbm_we, wbm_adr, we, adr);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      checks++;
      if ({cmd_ready, rsp_valid, rsp_dat, rsp_err, wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b valid=%b cyc=%b busy=%b adr=%h want all 0",
                  cmd_ready, rsp_valid, wbm_cyc, busy, wbm_adr);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL reset_release: ready=%b busy=%b want 1 0", cmd_ready, busy);
      end
      tick();
   endtask

   task automatic test_zero_wait_read();
      do_xfer(1'b0, 4'hF, 32'h3000_0004, 32'h1111_2222, 32'hA5A5_1234, 0, 0);
   endtask

   task automatic test_write_wait_states();
      do_xfer(1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 32'h7777_7777, 3, 1);
   endtask

   task automatic test_backpressure();
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'h3; cmd_adr = 32'h3000_0100; cmd_dat = 32'h0;
      tick();
      // Second command presented while the first is still running.
      cmd_we = 1'b1; cmd_sel = 4'hC; cmd_adr = 32'h3000_0200; cmd_dat = 32'h0BAD_F00D;
      slv_ack = 1'b1; slv_dat = 32'hCAFE_0001;
      tick();
      slv_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({rsp_valid, rsp_dat, cmd_ready, wbm_adr, wbm_we} !== {1'b1, 32'hCAFE_0001, 1'b0, 32'h3000_0100, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%b dat=%h ready=%b adr=%h we=%b want 1 cafe0001 0 30000100 0",
                     i, rsp_valid, rsp_dat, cmd_ready, wbm_adr, wbm_we);
         end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if ({cmd_ready, rsp_valid, wbm_cyc} !== 3'b100) begin
         errors++;
         $display("FAIL bp_idle: ready=%b valid=%b cyc=%b want 1 0 0", cmd_ready, rsp_valid, wbm_cyc);
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if ({wbm_cyc, wbm_we, wbm_sel, wbm_adr, wbm_dat} !== {1'b1, 1'b1, 4'hC, 32'h3000_0200, 32'h0BAD_F00D}) begin
         errors++;
         $display("FAIL bp_next_cmd: cyc=%b we=%b sel=%h adr=%h dat=%h want 1 1 c 30000200 0badf00d",
                  wbm_cyc, wbm_we, wbm_sel, wbm_adr, wbm_dat);
      end
      slv_ack = 1'b1; slv_dat = 32'h1234_5678;
      tick();
      slv_ack = 1'b0;
      checks++;
      if ({rsp_valid, rsp_dat, rsp_err} !== {1'b1, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL bp_next_rsp: valid=%b dat=%h err=%b want 1 0 0", rsp_valid, rsp_dat, rsp_err);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

`ifdef WBM_TIMEOUT_EN
   task automatic test_timeout();
      do_xfer(1'b0, 4'hF, 32'h3000_0020, 32'h0, 32'h5555_AAAA, NEVER, 2);
      do_xfer(1'b0, 4'hF, 32'h3000_0024, 32'h0, 32'h5555_AAAA, TMO - 1, 0);
      do_xfer(1'b1, 4'h1, 32'h3000_0028, 32'h99, 32'h0, NEVER, 0);
   endtask
`endif

   task automatic test_reset_mid_cycle();
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'h5; cmd_adr = 32'h3000_0300; cmd_dat = 32'hFFFF_0000;
      tick();
      cmd_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if ({cmd_ready, rsp_valid, rsp_dat, rsp_err, wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat, busy} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: ready=%b valid=%b cyc=%b stb=%b busy=%b adr=%h want all 0",
                  cmd_ready, rsp_valid, wbm_cyc, wbm_stb, busy, wbm_adr);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, rsp_valid, wbm_cyc} !== 3'b100) begin
         errors++;
         $display("FAIL rst_mid_release: ready=%b valid=%b cyc=%b want 1 0 0", cmd_ready, rsp_valid, wbm_cyc);
      end
      slv_ack = 1'b1;
      repeat (3) tick();
      slv_ack = 1'b0;
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL rst_mid_no_rsp: valid=%b busy=%b want 0 0", rsp_valid, busy);
      end
      do_xfer(1'b0, 4'hF, 32'h3000_0004, 32'h0, 32'h0F0F_0F0F, 1, 0);
   endtask

   task automatic test_spurious_ack_idle();
      logic [31:0] prev_dat;
      prev_dat = rsp_dat;
      slv_ack = 1'b1; slv_dat = 32'hBADB_AD00;
      repeat (2) tick();
      slv_ack = 1'b0;
      checks++;
      if ({cmd_ready, rsp_valid, wbm_cyc, busy, rsp_dat} !== {1'b1, 1'b0, 1'b0, 1'b0, prev_dat}) begin
         errors++;
         $display("FAIL spurious_idle: ready=%b valid=%b cyc=%b busy=%b dat=%h want 1 0 0 0 %h",
                  cmd_ready, rsp_valid, wbm_cyc, busy, rsp_dat, prev_dat);
      end
   endtask

   task automatic test_random(input int n);
      for (int i = 0; i < n; i++) begin
         do_xfer(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, $urandom,
                 (TMO < 7) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_zero_wait_read();
      test_write_wait_states();
      test_backpressure();
`ifdef WBM_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_cycle();
      test_spurious_ack_idle();
      test_random(40);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
